// File: rtl/ponteh_multi_if.sv
// ponteh_multi_if: bus bundle for the multi-channel H-bridge PWM controller.
//   fr    : carrier advance enable
//   we    : register write strobe
//   rgt   : register select (bit 0: 0=duty, 1=dir; upper bits: channel)
//   vlr   : write data (dir uses vlr[1:0])
//   sh/sa : forward / reverse drive, one bit per channel
//   wrap  : one-cycle pulse on carrier wrap
// master drives the register port and fr; slave (the controller) drives the pins.
interface ponteh_multi_if #(
    parameter int N_CH = 2,
    parameter int PW   = 8
);
    localparam int RW = $clog2(N_CH) + 1;

    logic            fr;
    logic            we;
    logic [RW-1:0]   rgt;
    logic [PW-1:0]   vlr;
    logic [N_CH-1:0] sh;
    logic [N_CH-1:0] sa;
    logic            wrap;

    modport master (output fr, we, rgt, vlr, input sh, sa, wrap);
    modport slave  (input fr, we, rgt, vlr, output sh, sa, wrap);
endinterface

// File: rtl/ponteh_multi.sv
// ponteh_multi: N_CH-channel H-bridge PWM controller with a shared carrier.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ponteh_multi_if.slave (fr, we, rgt, vlr in; sh, sa, wrap out)
// Parameters: N_CH channels (1..8), PW carrier bits (2..16), DT dead-time cycles (>=1).
// Optional feature macro: PONTEH_RAMP_EN (soft-start / soft-reversal duty ramp).
//
// Per-channel FSM:
//   state    | meaning
//   COAST    | sa=0 sh=0
//   FWD      | sh=pwm sa=0
//   REV      | sa=pwm sh=0
//   BRAKE    | sa=1 sh=1
//   DEAD     | sa=0 sh=0, dtc counts down to 0 before leaving
module ponteh_multi #(
    parameter int N_CH = 2,
    parameter int PW   = 8,
    parameter int DT   = 4
) (
    input  logic clk,
    input  logic rst_n,
    ponteh_multi_if.slave bus
);
    localparam int RW  = $clog2(N_CH) + 1;
    localparam int DTW = (DT > 1) ? $clog2(DT) : 1;
    localparam logic [PW-1:0] CNT_TOP = {{(PW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    logic [PW-1:0]   cnt;
    logic [PW-1:0]   cnt_nxt;
    logic            wrap_tick;
    logic [RW-1:0]   wsel;
    wire  [N_CH-1:0] sh_nxt;
    wire  [N_CH-1:0] sa_nxt;

    assign wrap_tick = bus.fr && (cnt == CNT_TOP);
    assign wsel      = bus.rgt >> 1;

    always_comb begin
        cnt_nxt = cnt;
        if (wrap_tick)   cnt_nxt = '0;
        else if (bus.fr) cnt_nxt = cnt + 1'b1;
    end

    // Pins are registered from next-state values so that, after an edge,
    // they reflect the state and carrier position held by that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bus.wrap <= 1'b0;
            bus.sh   <= '0;
            bus.sa   <= '0;
        end else begin
            cnt      <= cnt_nxt;
            bus.wrap <= wrap_tick;
            bus.sh   <= sh_nxt;
            bus.sa   <= sa_nxt;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PW-1:0]  duty_sh;
        logic [PW-1:0]  duty_act;
        logic [PW-1:0]  duty_act_nxt;
        logic [1:0]     dir;
        logic [DTW-1:0] dtc;
        logic [DTW-1:0] dtc_nxt;
        state_t         st;
        state_t         st_nxt;
        state_t         dir_st;
        logic           sel_w;
        logic           pwm_nxt;

        assign sel_w = bus.we && (wsel == RW'(i));

        always_comb begin
            dir_st = ST_COAST;
            case (dir)
                2'b01:   dir_st = ST_FWD;
                2'b10:   dir_st = ST_REV;
                2'b11:   dir_st = ST_BRAKE;
                default: dir_st = ST_COAST;
            endcase
        end

        // Leaving FWD/REV always passes through DEAD; a dir change while in
        // DEAD does not reload dtc.
        always_comb begin
            st_nxt  = st;
            dtc_nxt = dtc;
            case (st)
                ST_FWD, ST_REV: begin
                    if (dir_st != st) begin
                        st_nxt  = ST_DEAD;
                        dtc_nxt = DTW'(DT - 1);
                    end
                end
                ST_DEAD: begin
                    if (dtc == '0) st_nxt  = dir_st;
                    else           dtc_nxt = dtc - 1'b1;
                end
                default: st_nxt = dir_st;
            endcase
        end

        always_comb begin
            duty_act_nxt = duty_act;
            if (wrap_tick) begin
`ifdef PONTEH_RAMP_EN
                if (duty_act < duty_sh)      duty_act_nxt = duty_act + 1'b1;
                else if (duty_act > duty_sh) duty_act_nxt = duty_act - 1'b1;
`else
                duty_act_nxt = duty_sh;
`endif
            end
`ifdef PONTEH_RAMP_EN
            // New direction restarts from zero duty.
            if ((st_nxt == ST_DEAD) && (st != ST_DEAD)) duty_act_nxt = '0;
`endif
        end

        assign pwm_nxt   = cnt_nxt < duty_act_nxt;
        assign sh_nxt[i] = (st_nxt == ST_BRAKE) || ((st_nxt == ST_FWD) && pwm_nxt);
        assign sa_nxt[i] = (st_nxt == ST_BRAKE) || ((st_nxt == ST_REV) && pwm_nxt);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_sh  <= '0;
                duty_act <= '0;
                dir      <= 2'b00;
                dtc      <= '0;
                st       <= ST_COAST;
            end else begin
                if (sel_w && !bus.rgt[0]) duty_sh <= bus.vlr;
                if (sel_w &&  bus.rgt[0]) dir     <= bus.vlr[1:0];
                duty_act <= duty_act_nxt;
                dtc      <= dtc_nxt;
                st       <= st_nxt;
            end
        end
    end
endmodule

// File: tb/tb_ponteh_multi.sv
// tb_ponteh_multi: directed bench for ponteh_multi (N_CH=3, PW=4, DT=3).
// A small carrier model (m_cnt/m_wrap) tracks the expected counter position;
// pin expectations are written per step from the commanded mode and duty.
module tb_ponteh_multi;
    localparam int N_CH = 3;
    localparam int PW   = 4;
    localparam int DT   = 3;
    localparam int RW   = $clog2(N_CH) + 1;
    localparam int TOP  = (1 << PW) - 2;

    localparam int M_OFF = 0;
    localparam int M_FWD = 1;
    localparam int M_REV = 2;
    localparam int M_BRK = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ponteh_multi_if #(.N_CH(N_CH), .PW(PW)) bus ();

    ponteh_multi #(.N_CH(N_CH), .PW(PW), .DT(DT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int m_cnt = 0;
    bit m_wrap = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_wrap = (bus.fr === 1'b1) && (m_cnt == TOP);
        if (bus.fr === 1'b1) m_cnt = m_wrap ? 0 : m_cnt + 1;
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int isdir, input int val);
        bus.rgt = RW'(ch * 2 + isdir);
        bus.vlr = PW'(val);
        bus.we  = 1'b1;
        step();
        bus.we  = 1'b0;
    endtask

    // Step at least once, then until the model says a wrap edge just passed.
    task automatic to_wrap();
        int n;
        n = 0;
        step();
        while (!m_wrap && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic pins(input string tag, input int ch, input int mode, input int duty);
        logic       p;
        logic [1:0] e;
        p = (m_cnt < duty);
        e[1] = (mode == M_BRK) || ((mode == M_REV) && p);
        e[0] = (mode == M_BRK) || ((mode == M_FWD) && p);
        chk(tag, 16'({bus.sa[ch], bus.sh[ch]}), 16'(e));
    endtask

    task automatic chk_run(input string tag, input int ch, input int mode, input int duty, input int n);
        for (int i = 0; i < n; i++) begin
            pins(tag, ch, mode, duty);
            chk({tag, "_wrap"}, 16'(bus.wrap), 16'(m_wrap));
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        bus.fr  = 1'b1;
        bus.we  = 1'b0;
        bus.rgt = '0;
        bus.vlr = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sa", 16'(bus.sa), 16'd0);
        chk("rst_sh", 16'(bus.sh), 16'd0);
        chk("rst_wrap", 16'(bus.wrap), 16'd0);
        rst_n  = 1'b1;
        m_cnt  = 0;
        m_wrap = 1'b0;

        for (int i = 1; i <= 15; i++) begin
            step();
            chk("wrap_period", 16'(bus.wrap), 16'(i == 15));
        end

`ifdef PONTEH_RAMP_EN
        wr(0, 1, 1);
        wr(0, 0, 3);
        to_wrap();
        chk_run("ramp1", 0, M_FWD, 1, 15);
        chk_run("ramp2", 0, M_FWD, 2, 15);
        chk_run("ramp3", 0, M_FWD, 3, 15);
        chk_run("ramp_hold", 0, M_FWD, 3, 15);
        wr(0, 1, 2);
        step();
        chk_run("ramp_dead", 0, M_OFF, 0, 3);
        for (int i = 0; i < 20 && !m_wrap; i++) begin
            pins("ramp_rev0", 0, M_REV, 0);
            step();
        end
        chk_run("ramp_rev1", 0, M_REV, 1, 15);
        chk_run("ramp_rev2", 0, M_REV, 2, 15);
`else
        // Forward PWM, duty 5
        wr(0, 0, 5);
        wr(0, 1, 1);
        to_wrap();
        chk_run("pwm_fwd", 0, M_FWD, 5, 15);
        chk("wrap_again", 16'(bus.wrap), 16'd1);

        // Reversal FWD -> REV: exactly DT dead cycles
        wr(0, 1, 2);
        step();
        chk_run("rev_dead", 0, M_OFF, 0, 3);
        chk_run("rev_pwm", 0, M_REV, 5, 15);

        // REV -> FWD, then back to REV while dead: dead still lasts DT cycles
        wr(0, 1, 1);
        step();
        pins("dead2_a", 0, M_OFF, 0);
        wr(0, 1, 2);
        pins("dead2_b", 0, M_OFF, 0);
        step();
        pins("dead2_c", 0, M_OFF, 0);
        step();
        chk_run("rev2_pwm", 0, M_REV, 5, 15);

        // Back to FWD, then duty extremes
        wr(0, 1, 1);
        step();
        chk_run("fwd_dead", 0, M_OFF, 0, 3);
        chk_run("fwd_pwm", 0, M_FWD, 5, 4);
        wr(0, 0, 0);
        to_wrap();
        chk_run("duty_zero", 0, M_FWD, 0, 15);
        wr(0, 0, 15);
        to_wrap();
        chk_run("duty_max", 0, M_FWD, 15, 15);

        // Brake on ch1 from COAST, ch0 unaffected
        wr(1, 1, 3);
        pins("brake_pre", 1, M_OFF, 0);
        step();
        pins("brake_ch1", 1, M_BRK, 0);
        pins("brake_ch0", 0, M_FWD, 15);
        pins("brake_ch2", 2, M_OFF, 0);

        // Writes to channel index 3 are ignored
        wr(3, 0, 9);
        wr(3, 1, 2);
        to_wrap();
        for (int i = 0; i < 15; i++) begin
            pins("bad_ch0", 0, M_FWD, 15);
            pins("bad_ch1", 1, M_BRK, 0);
            pins("bad_ch2", 2, M_OFF, 0);
            chk("bad_wrap", 16'(bus.wrap), 16'(m_wrap));
            step();
        end

        // FR gating: carrier frozen, dead-time still counts clk cycles
        bus.fr = 1'b0;
        wr(0, 1, 2);
        step();
        chk_run("fr0_dead", 0, M_OFF, 0, 3);
        chk_run("fr0_rev", 0, M_REV, 15, 15);
        bus.fr = 1'b1;
        chk_run("fr1_rev", 0, M_REV, 15, 20);

        // Reset mid-run with ch0 in FWD and sh[0]=1
        wr(0, 1, 1);
        step();
        chk_run("pre_rst_dead", 0, M_OFF, 0, 3);
        pins("pre_rst_fwd", 0, M_FWD, 15);
        #2;
        rst_n   = 1'b0;
        bus.we  = 1'b1;
        bus.rgt = RW'(1);
        bus.vlr = PW'(3);
        #1;
        chk("async_rst_sa", 16'(bus.sa), 16'd0);
        chk("async_rst_sh", 16'(bus.sh), 16'd0);
        chk("async_rst_wrap", 16'(bus.wrap), 16'd0);
        @(negedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pins("post_rst_ch0", 0, M_OFF, 0);
            pins("post_rst_ch1", 1, M_OFF, 0);
            chk("post_rst_wrap", 16'(bus.wrap), 16'(i == 15));
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
